// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase countdown timer.
// State encoding is fixed so that debug probes and readback logic can decode it directly.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clkin down to a single-cycle tick every PRESCALE cycles.
// The counter only advances while enabled and restarts from zero on clear.
module tick_prescaler #(
  parameter int PRESCALE = 50000000,
  parameter int PRESC_W  = $clog2(PRESCALE)
) (
  input  logic clkin,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] count;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + PRESC_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/phase_timer.sv
// Programmable countdown timer for traffic-light phase durations.
// Counts raw clock cycles or prescaled one-second ticks, with one-shot/auto-reload, pause and abort.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 50000000,
  parameter int PRESC_W  = $clog2(PRESCALE)
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             start,
  input  logic [CNT_W-1:0] value,
  input  logic             seconds_enabled,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining_nxt;
  logic               expired_nxt;
  logic               done_nxt;
  logic               presc_enable;
  logic               presc_clear;
  logic               presc_tick;
  logic               tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PRESC_W  (PRESC_W)
  ) u_prescaler (
    .clkin  (clkin),
    .resetn (resetn),
    .enable (presc_enable),
    .clear  (presc_clear),
    .tick   (presc_tick)
  );

  assign tick = seconds_enabled ? presc_tick : 1'b1;

  // Prescaler is held at zero in fast mode so switching to seconds starts a fresh period.
  assign presc_clear  = start | abort | ~seconds_enabled;
  assign presc_enable = (state == RUN) & ~pause & seconds_enabled;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    expired_nxt   = 1'b0;
    done_nxt      = done;

    if (abort) begin
      state_nxt     = IDLE;
      remaining_nxt = '0;
      done_nxt      = 1'b0;
    end else if (start) begin
      remaining_nxt = value;
      done_nxt      = 1'b0;
      if (value == '0) begin
        state_nxt   = DONE;
        done_nxt    = 1'b1;
        expired_nxt = 1'b1;
      end else begin
        state_nxt = pause ? PAUSED : RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick) begin
            if (remaining > CNT_W'(1)) begin
              remaining_nxt = remaining - CNT_W'(1);
            end else begin
              // A zero reload value cannot run again, so it finishes like a one-shot.
              expired_nxt = 1'b1;
              if (auto_reload && (value != '0)) begin
                remaining_nxt = value;
              end else begin
                remaining_nxt = '0;
                done_nxt      = 1'b1;
                state_nxt     = DONE;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_nxt = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      expired   <= expired_nxt;
      done      <= done_nxt;
    end
  end

  assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_phase_timer.sv
// Directed self-checking bench for phase_timer with PRESCALE=3 and CNT_W=8.
// All stimulus changes and samples happen 1ns after the rising edge.
module tb_phase_timer;

  localparam int CNT_W    = 8;
  localparam int PRESCALE = 3;

  logic             clkin;
  logic             resetn;
  logic             start;
  logic [CNT_W-1:0] value;
  logic             seconds_enabled;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             expired;
  logic             done;

  int checks;
  int failures;

  phase_timer #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clkin           (clkin),
    .resetn          (resetn),
    .start           (start),
    .value           (value),
    .seconds_enabled (seconds_enabled),
    .auto_reload     (auto_reload),
    .pause           (pause),
    .abort           (abort),
    .remaining       (remaining),
    .busy            (busy),
    .expired         (expired),
    .done            (done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] v, input logic a);
    start = s;
    value = v;
    abort = a;
  endtask

  task automatic checkOutput(input string tag, input int exp_rem, input logic exp_busy,
                             input logic exp_exp, input logic exp_done);
    checks++;
    assert ({remaining, busy, expired, done} ===
            {CNT_W'(exp_rem), exp_busy, exp_exp, exp_done})
    else begin
      failures++;
      $error("[TB] FAIL %s observed rem=%0d busy=%0b exp=%0b done=%0b expected rem=%0d busy=%0b exp=%0b done=%0b",
             tag, remaining, busy, expired, done, exp_rem, exp_busy, exp_exp, exp_done);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    resetn          = 1'b0;
    seconds_enabled = 1'b0;
    auto_reload     = 1'b0;
    pause           = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    cycle(2);
    checkOutput("reset_state", 0, 0, 0, 0);
    resetn = 1'b1;
    cycle(1);

    // One-shot fast: 4,3,2,1 then 0 with expiry on edge E+4.
    applyStimulus(1'b1, 8'd4, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd4, 1'b0);
    checkOutput("oneshot_load", 4, 1, 0, 0);
    for (int i = 3; i >= 1; i--) begin
      cycle(1);
      checkOutput("oneshot_count", i, 1, 0, 0);
    end
    cycle(1);
    checkOutput("oneshot_expire", 0, 0, 1, 1);
    cycle(1);
    checkOutput("oneshot_after", 0, 0, 0, 1);

    // Pause is ignored in DONE.
    pause = 1'b1;
    cycle(1);
    checkOutput("done_pause", 0, 0, 0, 1);
    pause = 1'b0;

    // value=0 start: straight to DONE with a pulse in the following cycle.
    applyStimulus(1'b1, 8'd0, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("zero_start", 0, 0, 1, 1);
    cycle(1);
    checkOutput("zero_after", 0, 0, 0, 1);

    // start and abort together: abort wins, done clears.
    applyStimulus(1'b1, 8'd5, 1'b1);
    cycle(1);
    applyStimulus(1'b0, 8'd5, 1'b0);
    checkOutput("start_abort", 0, 0, 0, 0);

    // Abort coinciding with the final tick suppresses the pulse.
    applyStimulus(1'b1, 8'd1, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd1, 1'b1);
    checkOutput("one_load", 1, 1, 0, 0);
    cycle(1);
    applyStimulus(1'b0, 8'd1, 1'b0);
    checkOutput("abort_on_tick", 0, 0, 0, 0);
    cycle(1);
    checkOutput("abort_no_pulse", 0, 0, 0, 0);

    // Pause two edges at remaining=3, plus the resume edge: expiry moves from E+5 to E+8.
    applyStimulus(1'b1, 8'd5, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd5, 1'b0);
    cycle(2);
    checkOutput("pause_pre", 3, 1, 0, 0);
    pause = 1'b1;
    cycle(1);
    checkOutput("pause_enter", 3, 1, 0, 0);
    cycle(1);
    checkOutput("pause_hold", 3, 1, 0, 0);
    pause = 1'b0;
    cycle(1);
    checkOutput("pause_resume", 3, 1, 0, 0);
    cycle(1);
    checkOutput("pause_count2", 2, 1, 0, 0);
    cycle(1);
    checkOutput("pause_count1", 1, 1, 0, 0);
    cycle(1);
    checkOutput("pause_expire", 0, 0, 1, 1);

    // Restart mid-run at remaining=2 with value=7.
    applyStimulus(1'b1, 8'd5, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd5, 1'b0);
    cycle(3);
    checkOutput("restart_pre", 2, 1, 0, 0);
    applyStimulus(1'b1, 8'd7, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd7, 1'b0);
    checkOutput("restart_load", 7, 1, 0, 0);
    cycle(1);
    checkOutput("restart_count", 6, 1, 0, 0);
    applyStimulus(1'b0, 8'd7, 1'b1);
    cycle(1);
    applyStimulus(1'b0, 8'd7, 1'b0);
    checkOutput("restart_abort", 0, 0, 0, 0);

    // Prescaled auto-reload, PRESCALE=3, value=2: expiry at E+6 and E+12.
    seconds_enabled = 1'b1;
    auto_reload     = 1'b1;
    applyStimulus(1'b1, 8'd2, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd2, 1'b0);
    checkOutput("presc_load", 2, 1, 0, 0);
    cycle(2);
    checkOutput("presc_hold", 2, 1, 0, 0);
    cycle(1);
    checkOutput("presc_dec", 1, 1, 0, 0);
    cycle(2);
    checkOutput("presc_pre_exp", 1, 1, 0, 0);
    cycle(1);
    checkOutput("presc_reload1", 2, 1, 1, 0);
    cycle(1);
    checkOutput("presc_pulse_end", 2, 1, 0, 0);
    cycle(4);
    checkOutput("presc_mid", 1, 1, 0, 0);
    cycle(1);
    checkOutput("presc_reload2", 2, 1, 1, 0);
    // Dropping auto_reload turns the next expiry (E+18) into a one-shot finish.
    auto_reload = 1'b0;
    cycle(5);
    checkOutput("presc_last_pre", 1, 1, 0, 0);
    cycle(1);
    checkOutput("presc_oneshot", 0, 0, 1, 1);

    // Asynchronous reset mid-run at remaining=5, asserted between edges.
    seconds_enabled = 1'b0;
    applyStimulus(1'b1, 8'd5, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 8'd5, 1'b0);
    checkOutput("reset_pre", 5, 1, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("reset_async", 0, 0, 0, 0);
    cycle(1);
    resetn = 1'b1;
    cycle(1);
    checkOutput("reset_release", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
